// File: rtl/pito_pkg.sv
// Shared constants and types for the pito UART hub.
// Register map offsets, STATUS bit indices, drain FSM states.
package pito_pkg;

  localparam logic [31:0] OFF_TXDATA = 32'h0;
  localparam logic [31:0] OFF_RXDATA = 32'h4;
  localparam logic [31:0] OFF_STATUS = 32'h8;
  localparam logic [31:0] OFF_CTRL   = 32'hC;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_OVF   = 5;
  localparam int ST_BUSY     = 6;
  localparam int ST_TX_CNT   = 8;
  localparam int ST_RX_CNT   = 16;

  typedef enum logic [1:0] {
    DR_IDLE = 2'd0,
    DR_SEND = 2'd1,
    DR_HOLD = 2'd2
  } drain_e;

endpackage

// File: rtl/pito_sync_fifo.sv
// Synchronous FIFO with show-ahead head; push on full is
// accepted only when a pop happens in the same cycle.
module pito_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pito_uart_hub.sv
// Memory-mapped multi-channel UART hub: per-channel TX/RX
// FIFOs, drain FSM, STATUS/CTRL registers and level IRQs.
module pito_uart_hub
  import pito_pkg::*;
#(
  parameter int          NUM_CH     = 2,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter logic [31:0] CH_STRIDE  = 32'h10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o,
  output logic                  rvalid_o,
  output logic                  hit_o,
  output logic [NUM_CH-1:0]     uart_wr_o,
  output logic [NUM_CH*8-1:0]   uart_tx_data_o,
  input  logic [NUM_CH-1:0]     uart_busy_i,
  input  logic [NUM_CH*8-1:0]   uart_rx_data_i,
  input  logic [NUM_CH-1:0]     uart_valid_i,
  output logic [NUM_CH-1:0]     irq_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [32:0] END_ADDR =
    {1'b0, BASE_ADDR} + 33'(NUM_CH) * {1'b0, CH_STRIDE};

  logic [31:0]              off;
  logic [31:0]              ch_idx;
  logic [31:0]              reg_off;
  logic                     bus_wr;
  logic                     bus_rd;
  logic [NUM_CH-1:0][31:0]  rd_val;
  logic [31:0]              rd_mux;
  logic                     unused_wdata;

  assign hit_o   = (addr_i >= BASE_ADDR) &&
                   ({1'b0, addr_i} < END_ADDR);
  assign off     = addr_i - BASE_ADDR;
  assign ch_idx  = off / CH_STRIDE;
  assign reg_off = off % CH_STRIDE;
  assign bus_wr  = req_i && we_i && hit_o;
  assign bus_rd  = req_i && !we_i && hit_o;
  assign unused_wdata = ^wdata_i[31:8];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic          sel;
    logic          tx_push, tx_pop, rx_pop;
    logic          st_w, ctrl_w;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          tx_ovf, rx_ovf;
    logic [7:0]    tx_head, rx_head, tx_q;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic [1:0]    ctrl;
    logic [31:0]   status;
    logic [31:0]   rv;
    drain_e        st, st_nx;

    assign sel     = hit_o && (ch_idx == 32'(i));
    assign tx_push = bus_wr && sel && (reg_off == OFF_TXDATA);
    assign st_w    = bus_wr && sel && (reg_off == OFF_STATUS);
    assign ctrl_w  = bus_wr && sel && (reg_off == OFF_CTRL);
    assign rx_pop  = bus_rd && sel && (reg_off == OFF_RXDATA)
                     && !rx_empty;
    assign tx_pop  = (st == DR_SEND);

    pito_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_push),
      .pop   (tx_pop),
      .wdata (wdata_i[7:0]),
      .rdata (tx_head),
      .count (tx_cnt),
      .full  (tx_full),
      .empty (tx_empty)
    );

    pito_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx (
      .clk   (clk),
      .rst   (rst),
      .push  (uart_valid_i[i]),
      .pop   (rx_pop),
      .wdata (uart_rx_data_i[i*8 +: 8]),
      .rdata (rx_head),
      .count (rx_cnt),
      .full  (rx_full),
      .empty (rx_empty)
    );

    // Drain FSM state register
    always_ff @(posedge clk) begin
      if (rst) st <= DR_IDLE;
      else     st <= st_nx;
    end

    // Drain FSM next-state logic
    always_comb begin
      st_nx = st;
      unique case (st)
        DR_IDLE: if (!tx_empty && !uart_busy_i[i]) st_nx = DR_SEND;
        DR_SEND: st_nx = DR_HOLD;
        DR_HOLD: if (!uart_busy_i[i]) st_nx = DR_IDLE;
        default: st_nx = DR_IDLE;
      endcase
    end

    // Latch the outgoing byte on entry to SEND so it holds afterwards
    always_ff @(posedge clk) begin
      if (rst) tx_q <= '0;
      else if (st == DR_IDLE && st_nx == DR_SEND) tx_q <= tx_head;
    end

    // Sticky overflow flags (a new overflow beats a W1C) and CTRL
    always_ff @(posedge clk) begin
      if (rst) begin
        tx_ovf <= 1'b0;
        rx_ovf <= 1'b0;
        ctrl   <= '0;
      end else begin
        if (st_w && wdata_i[ST_TX_OVF]) tx_ovf <= 1'b0;
        if (st_w && wdata_i[ST_RX_OVF]) rx_ovf <= 1'b0;
        if (tx_push && tx_full && !tx_pop) tx_ovf <= 1'b1;
        if (uart_valid_i[i] && rx_full && !rx_pop) rx_ovf <= 1'b1;
        if (ctrl_w) ctrl <= wdata_i[1:0];
      end
    end

    // STATUS word assembly
    always_comb begin
      status = '0;
      status[ST_TX_FULL]    = tx_full;
      status[ST_TX_EMPTY]   = tx_empty;
      status[ST_RX_EMPTY]   = rx_empty;
      status[ST_RX_FULL]    = rx_full;
      status[ST_TX_OVF]     = tx_ovf;
      status[ST_RX_OVF]     = rx_ovf;
      status[ST_BUSY]       = uart_busy_i[i];
      status[ST_TX_CNT +: 8] = 8'(tx_cnt);
      status[ST_RX_CNT +: 8] = 8'(rx_cnt);
    end

    // Per-channel read mux
    always_comb begin
      rv = '0;
      if (reg_off == OFF_RXDATA && !rx_empty)
        rv = {23'b0, 1'b1, rx_head};
      else if (reg_off == OFF_STATUS)
        rv = status;
      else if (reg_off == OFF_CTRL)
        rv = {30'b0, ctrl};
    end

    assign rd_val[i] = rv;
    assign uart_wr_o[i] = (st == DR_SEND) && !rst;
    assign uart_tx_data_o[i*8 +: 8] = tx_q;
    assign irq_o[i] = (ctrl[0] && !rx_empty) ||
                      (ctrl[1] && tx_empty && st == DR_IDLE);
  end

  // Channel select for read data
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (ch_idx == 32'(k)) rd_mux = rd_val[k];
  end

  // Registered read response, zero when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= bus_rd;
      rdata_o  <= bus_rd ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_pito_uart_hub.sv
// Scoreboard bench for pito_uart_hub: expected reads and
// transmit strobes are queued and checked by monitors.
module tb_pito_uart_hub;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        hit;
  logic [1:0]  uart_wr;
  logic [15:0] uart_tx_data;
  logic [1:0]  uart_busy;
  logic [15:0] rx_data;
  logic [1:0]  uart_valid;
  logic [1:0]  irq;

  logic busy0;
  logic busy1;
  assign uart_busy = {busy1, busy0};

  pito_uart_hub #(
    .NUM_CH     (2),
    .FIFO_DEPTH (8),
    .BASE_ADDR  (BASE),
    .CH_STRIDE  (32'h10)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req),
    .we_i           (we),
    .addr_i         (addr),
    .wdata_i        (wdata),
    .rdata_o        (rdata),
    .rvalid_o       (rvalid),
    .hit_o          (hit),
    .uart_wr_o      (uart_wr),
    .uart_tx_data_o (uart_tx_data),
    .uart_busy_i    (uart_busy),
    .uart_rx_data_i (rx_data),
    .uart_valid_i   (uart_valid),
    .irq_o          (irq)
  );

  typedef struct {
    logic [31:0] data;
    int          cyc;
    int          id;
  } rd_exp_t;

  rd_exp_t    rd_q[$];
  logic [7:0] tx_q0[$];
  logic [7:0] tx_q1[$];
  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int rd_id  = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ad(input int ch,
                                     input logic [31:0] off);
    return BASE + 32'(ch) * 32'h10 + off;
  endfunction

  // UART model for ch0: busy for 3 cycles after each strobe
  initial begin
    int bcnt;
    bcnt  = 0;
    busy0 = 0;
    forever begin
      @(negedge clk);
      if (uart_wr[0] === 1'b1) bcnt = 3;
      else if (bcnt > 0) bcnt--;
      busy0 = (bcnt > 0);
    end
  end

  // Read-response monitor
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge clk);
      if (rvalid === 1'b1) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected got=%h exp=none", rdata);
        end else begin
          e = rd_q.pop_front();
          chk($sformatf("rd%0d_data", e.id), rdata, e.data);
          chk($sformatf("rd%0d_lat", e.id), 32'(cyc), 32'(e.cyc));
        end
      end else begin
        chk("rd_idle_zero", rdata, 32'h0);
      end
    end
  end

  // Transmit-strobe monitor
  initial begin
    int last0;
    logic [7:0] e;
    last0 = -1;
    forever begin
      @(negedge clk);
      if (uart_wr[0] === 1'b1) begin
        if (tx_q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx0_unexpected got=%h exp=none",
                   uart_tx_data[7:0]);
        end else begin
          e = tx_q0.pop_front();
          chk("tx0_data", {24'h0, uart_tx_data[7:0]}, {24'h0, e});
        end
        if (last0 >= 0) begin
          checks++;
          if (cyc - last0 < 4) begin
            errors++;
            $display("FAIL tx0_gap got=%0d exp>=4", cyc - last0);
          end
        end
        last0 = cyc;
      end
      if (uart_wr[1] === 1'b1) begin
        if (tx_q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx1_unexpected got=%h exp=none",
                   uart_tx_data[15:8]);
        end else begin
          e = tx_q1.pop_front();
          chk("tx1_data", {24'h0, uart_tx_data[15:8]}, {24'h0, e});
        end
      end
    end
  end

  task automatic bus_wr(input int ch, input logic [31:0] off,
                        input logic [31:0] d);
    req   = 1;
    we    = 1;
    addr  = ad(ch, off);
    wdata = d;
    @(negedge clk);
    req = 0;
    we  = 0;
  endtask

  task automatic bus_rd(input int ch, input logic [31:0] off,
                        input logic [31:0] exp);
    rd_q.push_back('{exp, cyc + 1, rd_id});
    rd_id++;
    req  = 1;
    we   = 0;
    addr = ad(ch, off);
    @(negedge clk);
    req = 0;
  endtask

  task automatic rx_inj(input int ch, input logic [7:0] b);
    uart_valid[ch]       = 1'b1;
    rx_data[ch*8 +: 8]   = b;
    @(negedge clk);
    uart_valid = '0;
  endtask

  initial begin
    rst        = 1;
    req        = 0;
    we         = 0;
    addr       = '0;
    wdata      = '0;
    busy1      = 0;
    rx_data    = '0;
    uart_valid = '0;
    repeat (2) @(negedge clk);
    rst = 0;

    // Reset state and address decode
    chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
    chk("rst_wr", {30'h0, uart_wr}, 32'h0);
    chk("rst_txdata", {16'h0, uart_tx_data}, 32'h0);
    chk("rst_irq", {30'h0, irq}, 32'h0);
    addr = BASE;          #1 chk("hit_base", {31'h0, hit}, 32'h1);
    addr = BASE + 32'h1C; #1 chk("hit_top", {31'h0, hit}, 32'h1);
    addr = BASE + 32'h20; #1 chk("hit_end", {31'h0, hit}, 32'h0);
    addr = BASE - 32'h1;  #1 chk("hit_below", {31'h0, hit}, 32'h0);
    @(negedge clk);
    bus_rd(0, 32'h8, 32'h6);

    // Two bytes on ch0 with a 3-cycle busy per byte
    tx_q0.push_back(8'h41);
    tx_q0.push_back(8'h42);
    bus_wr(0, 32'h0, 32'h41);
    bus_wr(0, 32'h0, 32'h42);
    repeat (16) @(negedge clk);
    chk("tx0_drain", 32'(tx_q0.size()), 32'h0);
    bus_rd(0, 32'h0, 32'h0);

    // Overfill ch1 TX while busy, then W1C the overflow
    busy1 = 1;
    for (int k = 0; k < 9; k++) begin
      if (k < 8) tx_q1.push_back(8'h10 + 8'(k));
      bus_wr(1, 32'h0, 32'h10 + 32'(k));
    end
    bus_rd(1, 32'h8, 32'h0000_0855);
    bus_wr(1, 32'h8, 32'h10);
    bus_rd(1, 32'h8, 32'h0000_0845);
    chk("irq_idle", {30'h0, irq}, 32'h0);
    busy1 = 0;
    repeat (40) @(negedge clk);
    chk("tx1_drain", 32'(tx_q1.size()), 32'h0);

    // RX byte readback, empty read, irq disabled
    rx_inj(0, 8'h5A);
    chk("irq_rx_noen", {31'h0, irq[0]}, 32'h0);
    bus_rd(0, 32'h4, 32'h15A);
    bus_rd(0, 32'h4, 32'h0);

    // RX interrupt enable on ch0
    bus_wr(0, 32'hC, 32'hFFFF_FFFD);
    bus_rd(0, 32'hC, 32'h1);
    rx_inj(0, 8'h77);
    chk("irq_rx_set", {31'h0, irq[0]}, 32'h1);
    chk("irq_ch1_quiet", {31'h0, irq[1]}, 32'h0);
    bus_rd(0, 32'h4, 32'h177);
    chk("irq_rx_clr", {31'h0, irq[0]}, 32'h0);

    // Full RX FIFO with simultaneous pop and push on ch1
    for (int k = 0; k < 8; k++) rx_inj(1, 8'h80 + 8'(k));
    rd_q.push_back('{32'h180, cyc + 1, rd_id});
    rd_id++;
    req        = 1;
    we         = 0;
    addr       = ad(1, 32'h4);
    uart_valid = 2'b10;
    rx_data    = 16'h8800;
    @(negedge clk);
    req        = 0;
    uart_valid = '0;
    bus_rd(1, 32'h8, 32'h0008_000A);
    rx_inj(1, 8'h89);
    bus_rd(1, 32'h8, 32'h0008_002A);
    bus_wr(1, 32'h8, 32'h20);
    bus_rd(1, 32'h8, 32'h0008_000A);
    bus_rd(1, 32'h4, 32'h181);

    // Reset in the middle of a SEND on ch0
    bus_wr(0, 32'h0, 32'h99);
    @(posedge clk);
    #1;
    chk("send_entered", {31'h0, uart_wr[0]}, 32'h1);
    chk("send_data", {24'h0, uart_tx_data[7:0]}, 32'h99);
    rst = 1;
    @(negedge clk);
    chk("rst_cycle_wr", {30'h0, uart_wr}, 32'h0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("post_rst_wr", {30'h0, uart_wr}, 32'h0);
    chk("post_rst_txdata", {16'h0, uart_tx_data}, 32'h0);
    chk("post_rst_irq", {30'h0, irq}, 32'h0);
    chk("post_rst_rvalid", {31'h0, rvalid}, 32'h0);
    chk("post_rst_rdata", rdata, 32'h0);
    @(negedge clk);
    chk("post_rst_wr2", {30'h0, uart_wr}, 32'h0);
    bus_rd(0, 32'h8, 32'h6);
    bus_rd(1, 32'h8, 32'h6);

    repeat (4) @(negedge clk);
    chk("rd_queue_empty", 32'(rd_q.size()), 32'h0);
    chk("tx0_queue_empty", 32'(tx_q0.size()), 32'h0);
    chk("tx1_queue_empty", 32'(tx_q1.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pito_uart_hub.md
PITO_UART_HUB -- requirements
Module: pito_uart_hub

Interface
REQ-001 Parameter NUM_CH, default 2, SHALL set the number of UART channels (1..8).
REQ-002 Parameter FIFO_DEPTH, default 8, SHALL set per-channel TX and RX FIFO depth (power of two, 2..128).
REQ-003 Parameter BASE_ADDR, default 32'h8000_0000, SHALL set the byte address of channel 0.
REQ-004 Parameter CH_STRIDE, default 32'h10, SHALL set the byte spacing between channel register blocks.
REQ-005 Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
REQ-006 The port list SHALL be exactly:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_i  in  1  core data request.
- we_i  in  1  write enable, qualified by req_i.
- addr_i  in  32  byte address.
- wdata_i  in  32  write data.
- rdata_o  out  32  read data, registered.
- rvalid_o  out  1  rdata_o valid, one cycle after an accepted read hit.
- hit_o  out  1  combinational; addr_i is inside [BASE_ADDR, BASE_ADDR+NUM_CH*CH_STRIDE).
- uart_wr_o  out  NUM_CH  one-cycle transmit strobe per channel.
- uart_tx_data_o  out  NUM_CH*8  transmit byte per channel.
- uart_busy_i  in  NUM_CH  UART transmitter busy.
- uart_rx_data_i  in  NUM_CH*8  received byte.
- uart_valid_i  in  NUM_CH  one-cycle received-byte pulse.
- irq_o  out  NUM_CH  level interrupt per channel.

Function
REQ-007 Channel register offsets SHALL be: +0x0 TXDATA (W), +0x4 RXDATA (R), +0x8 STATUS (R, W1C), +0xC CTRL (RW).
- Any other offset SHALL read 0 and ignore writes.
REQ-008 Writing TXDATA SHALL push wdata_i[7:0] into the channel TX FIFO.
- If the FIFO is full and no pop occurs that cycle, the byte SHALL be dropped and sticky tx_ovf set.
REQ-009 Reading RXDATA SHALL return {23'b0, 1'b1, head[7:0]} and pop the RX FIFO in the request cycle.
- If the FIFO is empty, the read SHALL return 32'h0 and SHALL NOT pop.
REQ-010 STATUS bit assignment:
- [0] tx_full, [1] tx_empty, [2] rx_empty, [3] rx_full, [4] tx_ovf, [5] rx_ovf, [6] uart_busy_i.
- [15:8] tx_count, [23:16] rx_count, zero-extended; all other bits 0.
- Writing 1 to bit 4 or bit 5 SHALL clear that bit; writing 0 SHALL leave it unchanged.
REQ-011 CTRL bit assignment: [0] rx_irq_en, [1] tx_empty_irq_en; all other bits SHALL read 0.
REQ-012 Read latency: rdata_o and rvalid_o SHALL be registered and update exactly one cycle after a cycle with req_i && !we_i && hit_o.
- In all other cycles rvalid_o=0 and rdata_o=0.
REQ-013 A uart_valid_i pulse SHALL push uart_rx_data_i byte into the RX FIFO.
- If the FIFO is full and not popped that cycle, the byte SHALL be dropped and sticky rx_ovf set.
REQ-014 Simultaneous push and pop on a full FIFO SHALL accept both; the count SHALL stay unchanged.
REQ-015 Each channel SHALL run a drain FSM with states IDLE, SEND, HOLD:
- IDLE->SEND when TX FIFO non-empty and uart_busy_i=0.
- SEND: uart_wr_o=1 for one cycle, uart_tx_data_o=head, pop; then ->HOLD.
- HOLD: minimum one cycle; ->IDLE when uart_busy_i=0.
REQ-016 uart_tx_data_o SHALL hold the last sent byte outside SEND.
REQ-017 irq_o[ch] SHALL equal (rx_irq_en & !rx_empty) | (tx_empty_irq_en & tx_empty & FSM==IDLE).
REQ-018 Channels SHALL operate independently; the CPU access and a UART event on the same channel in the same cycle SHALL both take effect.

Reset
REQ-019 On rst=1, at the clock edge, every channel SHALL be reset:
- FIFOs empty, counts 0, tx_ovf=rx_ovf=0, CTRL=0, FSM=IDLE.
- rdata_o=0, rvalid_o=0, uart_wr_o=0, uart_tx_data_o=0, irq_o=0.
REQ-020 Reset asserted mid-transfer SHALL abort the transfer; no uart_wr_o SHALL be issued in the reset cycle or the cycle after.

Structure
REQ-021 pito_pkg SHALL hold the register offset constants, the STATUS bit indices and the drain-state enum typedef.
REQ-022 FIFOs SHALL be instances of a sub-module pito_sync_fifo (params WIDTH, DEPTH), 2*NUM_CH instances.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Write 0x41, 0x42 to ch0 TXDATA with busy held 3 cycles per byte -> two uart_wr_o[0] strobes, data 0x41 then 0x42, gap ≥ HOLD+busy.
- Write 9 bytes to ch1 TXDATA while busy=1 (depth 8) -> STATUS reads tx_full=1, tx_ovf=1, tx_count=8; W1C 0x10 -> tx_ovf=0.
- Pulse uart_valid_i[0] with 0x5A, then read RXDATA -> rdata_o=32'h15A with rvalid_o one cycle later; a second read -> 32'h0.
- Set CTRL=1 on ch0, inject an RX byte -> irq_o[0]=1 until RXDATA is read, then 0.
- Full RX FIFO with RXDATA read and uart_valid_i in the same cycle -> rx_count stays 8, rx_ovf=0.
- Assert rst during SEND -> all outputs 0 the next cycle; STATUS reads tx_empty=1, rx_empty=1.
